// File: rtl/frotaegis_pkg.sv
// Shared definitions for the frame report packer: packet framing constants
// and the serialiser state encoding.
package frotaegis_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam int         RES_BYTES = 6;

    // Whole packet: header, six result bytes, LENGTH samples, checksum.
    function automatic int PKT_LEN(input int length);
        return length + 8;
    endfunction

    typedef enum logic [2:0] {
        COLLECT,
        HDR,
        RES,
        FRAME,
        CSUM
    } state_t;

endpackage

// File: rtl/frame_sample_buf.sv
// Frame sample store: one synchronous write port and one combinational
// read port, so the serialiser can prefetch the next sample byte.
module frame_sample_buf #(
    parameter int DATA_SIZE   = 4,
    parameter int LENGTH      = 64,
    parameter int LENGTH_SIZE = 6
) (
    input  logic                   clk,
    input  logic                   wrEn,
    input  logic [LENGTH_SIZE-1:0] wrAdd,
    input  logic [DATA_SIZE-1:0]   wrData,
    input  logic [LENGTH_SIZE-1:0] rdAdd,
    output logic [DATA_SIZE-1:0]   rdData
);

    logic [DATA_SIZE-1:0] mem [LENGTH];

    // Storage is never cleared; unwritten addresses keep old contents.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAdd] <= wrData;
        end
    end

    assign rdData = mem[rdAdd];

endmodule

// File: rtl/frame_report_packer.sv
// Collects one frame plus the top-3 sort result, then streams them out as a
// single checksummed byte packet on a valid/ready byte interface.
module frame_report_packer
    import frotaegis_pkg::*;
#(
    parameter int         DATA_SIZE   = 4,
    parameter int         LENGTH      = 64,
    parameter int         LENGTH_SIZE = 6,
    parameter logic [7:0] HDR_BYTE    = frotaegis_pkg::HDR_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   FramEn,
    input  logic [LENGTH_SIZE-1:0] FramAdd,
    input  logic [DATA_SIZE-1:0]   FramData,
    input  logic                   SortValid,
    input  logic [DATA_SIZE-1:0]   MaxCountData1,
    input  logic [DATA_SIZE-1:0]   MaxCountData2,
    input  logic [DATA_SIZE-1:0]   MaxCountData3,
    input  logic [LENGTH_SIZE-1:0] MaxCount1,
    input  logic [LENGTH_SIZE-1:0] MaxCount2,
    input  logic [LENGTH_SIZE-1:0] MaxCount3,
    output logic [7:0]             TxData,
    output logic                   TxValid,
    input  logic                   TxReady,
    output logic                   TxLast,
    output logic                   Busy,
    output logic                   Overrun
);

    // Frame payload is what remains after header, results and checksum.
    localparam int LAST_FRAME_IDX = PKT_LEN(LENGTH) - RES_BYTES - 3;
    localparam int IDX_W          = (LENGTH_SIZE > 3) ? LENGTH_SIZE : 3;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic                   frameDone;
    logic                   sortDone;
    logic [DATA_SIZE-1:0]   maxData1, maxData2, maxData3;
    logic [LENGTH_SIZE-1:0] maxCnt1, maxCnt2, maxCnt3;
    logic [7:0]             csum;
    logic [7:0]             csumNext;
    logic [7:0]             nextByte;
    logic [LENGTH_SIZE-1:0] rdAdd;
    logic [DATA_SIZE-1:0]   rdData;
    logic                   xfer;
    logic                   inCollect;
    logic                   bufWe;
    logic                   lastSample;
    logic                   startPkt;

    function automatic logic [7:0] zextData(input logic [DATA_SIZE-1:0] v);
        return 8'(v);
    endfunction

    function automatic logic [7:0] zextCnt(input logic [LENGTH_SIZE-1:0] v);
        return 8'(v);
    endfunction

    assign xfer       = TxValid && TxReady;
    assign inCollect  = (state == COLLECT);
    assign bufWe      = inCollect && FramEn;
    assign lastSample = bufWe && (FramAdd == LENGTH_SIZE'(LENGTH - 1));
    // Include this cycle's strobes so the header follows the enabling strobe by one cycle.
    assign startPkt   = inCollect && (frameDone || lastSample) && (sortDone || SortValid);
    assign csumNext   = csum + TxData;

    frame_sample_buf #(
        .DATA_SIZE   (DATA_SIZE),
        .LENGTH      (LENGTH),
        .LENGTH_SIZE (LENGTH_SIZE)
    ) u_buf (
        .clk    (clk),
        .wrEn   (bufWe),
        .wrAdd  (FramAdd),
        .wrData (FramData),
        .rdAdd  (rdAdd),
        .rdData (rdData)
    );

    // Byte to present after the current one is accepted (prefetch for registered TxData).
    always_comb begin
        nextByte = '0;
        rdAdd    = '0;
        case (state)
            HDR: nextByte = zextData(maxData1);
            RES: begin
                case (idx[2:0])
                    3'd0:    nextByte = zextCnt(maxCnt1);
                    3'd1:    nextByte = zextData(maxData2);
                    3'd2:    nextByte = zextCnt(maxCnt2);
                    3'd3:    nextByte = zextData(maxData3);
                    3'd4:    nextByte = zextCnt(maxCnt3);
                    default: nextByte = zextData(rdData);
                endcase
            end
            FRAME: begin
                rdAdd = LENGTH_SIZE'(idx + 1'b1);
                if (idx == IDX_W'(LAST_FRAME_IDX)) begin
                    nextByte = csumNext;
                end else begin
                    nextByte = zextData(rdData);
                end
            end
            default: nextByte = '0;
        endcase
    end

    // Capture control and packet serialiser; every step waits for a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= '0;
            frameDone <= 1'b0;
            sortDone  <= 1'b0;
            csum      <= '0;
            TxData    <= '0;
            TxValid   <= 1'b0;
            TxLast    <= 1'b0;
            Busy      <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            if (!inCollect && (FramEn || SortValid)) begin
                Overrun <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (lastSample) begin
                        frameDone <= 1'b1;
                    end
                    if (SortValid) begin
                        maxData1 <= MaxCountData1;
                        maxData2 <= MaxCountData2;
                        maxData3 <= MaxCountData3;
                        maxCnt1  <= MaxCount1;
                        maxCnt2  <= MaxCount2;
                        maxCnt3  <= MaxCount3;
                        sortDone <= 1'b1;
                    end
                    if (startPkt) begin
                        state   <= HDR;
                        idx     <= '0;
                        csum    <= '0;
                        TxData  <= HDR_BYTE;
                        TxValid <= 1'b1;
                        TxLast  <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state  <= RES;
                        idx    <= '0;
                        TxData <= nextByte;
                    end
                end
                RES: begin
                    if (xfer) begin
                        csum   <= csumNext;
                        TxData <= nextByte;
                        if (idx == IDX_W'(RES_BYTES - 1)) begin
                            state <= FRAME;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FRAME: begin
                    if (xfer) begin
                        csum   <= csumNext;
                        TxData <= nextByte;
                        if (idx == IDX_W'(LAST_FRAME_IDX)) begin
                            state  <= CSUM;
                            TxLast <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        state     <= COLLECT;
                        TxValid   <= 1'b0;
                        TxLast    <= 1'b0;
                        Busy      <= 1'b0;
                        frameDone <= 1'b0;
                        sortDone  <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_report_packer.sv
// Bench for frame_report_packer: a transaction-level model builds each
// expected packet from the captured frame and sort result and is compared
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_frame_report_packer;

    localparam int LEN = 64;
    localparam int PKT = 72;

    logic       clk = 1'b0;
    logic       rst;
    logic       FramEn;
    logic [5:0] FramAdd;
    logic [3:0] FramData;
    logic       SortValid;
    logic [3:0] MaxCountData1, MaxCountData2, MaxCountData3;
    logic [5:0] MaxCount1, MaxCount2, MaxCount3;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic       TxLast;
    logic       Busy;
    logic       Overrun;

    always #5 clk = ~clk;

    frame_report_packer dut (
        .clk           (clk),
        .rst           (rst),
        .FramEn        (FramEn),
        .FramAdd       (FramAdd),
        .FramData      (FramData),
        .SortValid     (SortValid),
        .MaxCountData1 (MaxCountData1),
        .MaxCountData2 (MaxCountData2),
        .MaxCountData3 (MaxCountData3),
        .MaxCount1     (MaxCount1),
        .MaxCount2     (MaxCount2),
        .MaxCount3     (MaxCount3),
        .TxData        (TxData),
        .TxValid       (TxValid),
        .TxReady       (TxReady),
        .TxLast        (TxLast),
        .Busy          (Busy),
        .Overrun       (Overrun)
    );

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [3:0] mMem [LEN];
    logic [7:0] mRes [6];
    bit         mFD    = 0;
    bit         mSD    = 0;
    bit         mInPkt = 0;
    bit         mOvr   = 0;
    logic [7:0] expQ [$];

    // Observation
    logic [7:0] got [$];
    int         busyCycles = 0;
    bit         rndReady   = 0;
    logic [7:0] ref1 [PKT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gotAt(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    task automatic buildPacket();
        int s;
        s = 0;
        expQ.delete();
        expQ.push_back(8'hA5);
        for (int i = 0; i < 6; i++) begin
            expQ.push_back(mRes[i]);
            s += int'(mRes[i]);
        end
        for (int i = 0; i < LEN; i++) begin
            expQ.push_back({4'b0, mMem[i]});
            s += int'(mMem[i]);
        end
        expQ.push_back(8'(s));
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelStep();
        if (rst) begin
            mFD = 0; mSD = 0; mInPkt = 0; mOvr = 0;
            expQ.delete();
        end else if (mInPkt) begin
            if (FramEn || SortValid) mOvr = 1;
            if (TxReady) begin
                void'(expQ.pop_front());
                if (expQ.size() == 0) begin
                    mInPkt = 0; mFD = 0; mSD = 0;
                end
            end
        end else begin
            if (FramEn) begin
                mMem[FramAdd] = FramData;
                if (FramAdd == 6'd63) mFD = 1;
            end
            if (SortValid) begin
                mRes[0] = {4'b0, MaxCountData1}; mRes[1] = {2'b0, MaxCount1};
                mRes[2] = {4'b0, MaxCountData2}; mRes[3] = {2'b0, MaxCount2};
                mRes[4] = {4'b0, MaxCountData3}; mRes[5] = {2'b0, MaxCount3};
                mSD = 1;
            end
            if (mFD && mSD) begin
                buildPacket();
                mInPkt = 1;
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    task automatic compareCycle();
        chk("TxValid", TxValid, mInPkt);
        chk("Busy", Busy, mInPkt);
        chk("Overrun", Overrun, mOvr);
        if (mInPkt) begin
            chk("TxData", TxData, expQ[0]);
            chk("TxLast", TxLast, expQ.size() == 1);
        end
        if (TxValid && TxReady) got.push_back(TxData);
        if (Busy) busyCycles++;
    endtask

    task automatic tick();
        @(negedge clk);
        compareCycle();
        @(posedge clk);
        modelStep();
        #1;
        if (rndReady) TxReady = 1'($urandom_range(0, 1));
    endtask

    task automatic sendFrame(input int mode);
        for (int a = 0; a < LEN; a++) begin
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                FramEn = 0;
                tick();
            end
            FramEn   = 1;
            FramAdd  = 6'(a);
            FramData = (mode == 1) ? 4'($urandom) : 4'(a);
            tick();
        end
        FramEn = 0;
    endtask

    task automatic sendSort(input logic [3:0] d1, input logic [5:0] c1,
                            input logic [3:0] d2, input logic [5:0] c2,
                            input logic [3:0] d3, input logic [5:0] c3);
        MaxCountData1 = d1; MaxCount1 = c1;
        MaxCountData2 = d2; MaxCount2 = c2;
        MaxCountData3 = d3; MaxCount3 = c3;
        SortValid = 1;
        tick();
        SortValid = 0;
    endtask

    task automatic sendSortRand();
        sendSort(4'($urandom), 6'($urandom), 4'($urandom), 6'($urandom),
                 4'($urandom), 6'($urandom));
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (mInPkt && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, n < 3000, 1);
        tick();
        tick();
    endtask

    task automatic waitGot(input string name, input int target);
        int n;
        n = 0;
        while (got.size() < target && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_wait"}, n < 3000, 1);
    endtask

    task automatic cmpStream(input string name, input int base);
        int diffs;
        diffs = 0;
        if (got.size() < base + PKT) diffs = 999;
        else for (int i = 0; i < PKT; i++) if (got[base + i] !== ref1[i]) diffs++;
        chk(name, diffs, 0);
    endtask

    initial begin
        int base;
        int b0;
        logic [7:0] held;
        logic [7:0] hdrLit [7];

        hdrLit = '{8'hA5, 8'h05, 8'h09, 8'h03, 8'h06, 8'h0C, 8'h04};
        for (int i = 0; i < 7; i++) ref1[i] = hdrLit[i];
        for (int i = 0; i < LEN; i++) ref1[7 + i] = 8'(i % 16);
        ref1[PKT - 1] = 8'h07;

        rst = 1; FramEn = 0; FramAdd = 0; FramData = 0; SortValid = 0; TxReady = 1;
        MaxCountData1 = 0; MaxCountData2 = 0; MaxCountData3 = 0;
        MaxCount1 = 0; MaxCount2 = 0; MaxCount3 = 0;
        repeat (3) @(posedge clk);
        #1;
        tick();
        chk("rst_TxValid", TxValid, 0);
        chk("rst_TxData", TxData, 0);
        chk("rst_TxLast", TxLast, 0);
        chk("rst_Busy", Busy, 0);
        chk("rst_Overrun", Overrun, 0);
        rst = 0;
        tick();

        // Basic packet with TxReady held high
        base = got.size();
        b0   = busyCycles;
        sendFrame(0);
        sendSort(4'h5, 6'd9, 4'h3, 6'd6, 4'hC, 6'd4);
        waitIdle("basic");
        chk("basic_len", got.size() - base, PKT);
        chk("basic_hdr", gotAt(base), 8'hA5);
        chk("basic_d1", gotAt(base + 1), 8'h05);
        chk("basic_c3", gotAt(base + 6), 8'h04);
        chk("basic_s17", gotAt(base + 7 + 17), 8'h01);
        chk("basic_csum", gotAt(base + PKT - 1), 8'h07);
        chk("basic_busy_cycles", busyCycles - b0, PKT);
        cmpStream("basic_stream", base);

        // Two sort results before the frame: latest wins
        base = got.size();
        sendSortRand();
        sendSort(4'h1, 6'd2, 4'h2, 6'd1, 4'h3, 6'd0);
        sendFrame(0);
        waitIdle("swap");
        chk("swap_d1", gotAt(base + 1), 8'h01);
        chk("swap_c1", gotAt(base + 2), 8'h02);
        chk("swap_d2", gotAt(base + 3), 8'h02);
        chk("swap_c2", gotAt(base + 4), 8'h01);
        chk("swap_d3", gotAt(base + 5), 8'h03);
        chk("swap_c3", gotAt(base + 6), 8'h00);
        chk("swap_csum", gotAt(base + PKT - 1), 8'hE9);

        // Backpressure on byte index 10
        base = got.size();
        sendFrame(0);
        sendSort(4'h5, 6'd9, 4'h3, 6'd6, 4'hC, 6'd4);
        waitGot("bp", base + 10);
        TxReady = 0;
        held = TxData;
        chk("bp_byte10", held, 8'h03);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_data", TxData, held);
            chk("bp_hold_valid", TxValid, 1);
            chk("bp_hold_last", TxLast, 0);
        end
        TxReady = 1;
        waitIdle("bp");
        cmpStream("bp_stream", base);

        // Inputs arriving during FRAME are flagged and ignored
        base = got.size();
        sendFrame(0);
        sendSort(4'h5, 6'd9, 4'h3, 6'd6, 4'hC, 6'd4);
        waitGot("ovr", base + 10);
        FramEn = 1; FramAdd = 6'd63; FramData = 4'hF;
        MaxCountData1 = 4'hF; MaxCount1 = 6'd63;
        SortValid = 1;
        tick();
        FramEn = 0; SortValid = 0;
        chk("ovr_set", Overrun, 1);
        waitIdle("ovr");
        cmpStream("ovr_stream", base);
        repeat (5) tick();
        chk("ovr_sticky", Overrun, 1);
        chk("ovr_no_pending", TxValid, 0);

        // Reset while byte 30 is pending
        base = got.size();
        sendFrame(0);
        sendSort(4'h5, 6'd9, 4'h3, 6'd6, 4'hC, 6'd4);
        waitGot("rstmid", base + 30);
        TxReady = 0;
        rst = 1;
        tick();
        rst = 0;
        TxReady = 1;
        chk("rstmid_TxValid", TxValid, 0);
        chk("rstmid_Busy", Busy, 0);
        chk("rstmid_Overrun", Overrun, 0);
        tick();
        base = got.size();
        sendFrame(0);
        sendSort(4'h5, 6'd9, 4'h3, 6'd6, 4'hC, 6'd4);
        waitIdle("rstmid");
        cmpStream("rstmid_stream", base);

        // SortValid coincident with the last sample
        for (int a = 0; a < LEN - 1; a++) begin
            FramEn = 1; FramAdd = 6'(a); FramData = 4'($urandom);
            tick();
        end
        FramAdd = 6'd63; FramData = 4'hA;
        MaxCountData1 = 4'h7; MaxCount1 = 6'd1;
        MaxCountData2 = 4'h6; MaxCount2 = 6'd2;
        MaxCountData3 = 4'h5; MaxCount3 = 6'd3;
        SortValid = 1;
        tick();
        FramEn = 0; SortValid = 0;
        chk("simul_valid", TxValid, 1);
        chk("simul_hdr", TxData, 8'hA5);
        waitIdle("simul");

        // Randomized packets with random TxReady and occasional overrun pulses
        rndReady = 1;
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                sendSortRand();
                if ($urandom_range(0, 1) == 1) sendSortRand();
                sendFrame(1);
            end else begin
                sendFrame(1);
                sendSortRand();
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat (5) tick();
                SortValid = 1;
                tick();
                SortValid = 0;
            end
            waitIdle("rand");
        end
        rndReady = 0;
        TxReady  = 1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
